// File: rtl/pid_pwm_pkg.sv
// Shared constants and helpers for the PID-to-PWM output block.
// Holds counter width default, minimum period, direction codes, saturating abs.
package pid_pwm_pkg;

    localparam int   CNT_W_DEF  = 16;
    localparam int   MIN_PERIOD = 2;
    localparam logic DIR_FWD    = 1'b0;
    localparam logic DIR_REV    = 1'b1;

    // Magnitude of a signed word; -2^31 has no positive twin, so it clips.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] s);
        if (s == {1'b1, 31'b0}) begin
            return 32'h7FFF_FFFF;
        end else if (s[31]) begin
            return -s;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time gate: holds block high for DEAD_CYCLES cycles after start.
// Ports: clk, rst (async high), en, start (pulse), block (force legs low).
module pwm_deadtime
    import pid_pwm_pkg::*;
#(
    parameter int DEAD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic start,
    output logic block
);

    localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

    logic [DW-1:0] dcnt;

    assign block = (dcnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= '0;
        end else if (start) begin
            dcnt <= DW'(DEAD_CYCLES);
        end else if (!en) begin
            dcnt <= '0;
        end else if (dcnt != '0) begin
            dcnt <= dcnt - DW'(1);
        end
    end

endmodule

// File: rtl/pid_pwm_out.sv
// PID output to H-bridge PWM: shift, abs, clamp, then boundary-synced PWM.
// Ports: CLK, RST (async high), EN, PID_OUT_Set, OUT_SHIFT_Set, PERIOD_Set,
//        PWM_A, PWM_B, DIR, DUTY_REG, SAT, PERIOD_TICK.
// Option: define PWM_DEADTIME_EN to gate both legs after a direction change.
module pid_pwm_out
    import pid_pwm_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int DEAD_CYCLES    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [31:0]      PID_OUT_Set,
    input  logic [4:0]       OUT_SHIFT_Set,
    input  logic [CNT_W-1:0] PERIOD_Set,
    output logic             PWM_A,
    output logic             PWM_B,
    output logic             DIR,
    output logic [CNT_W-1:0] DUTY_REG,
    output logic             SAT,
    output logic             PERIOD_TICK
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    // input protect registers
    logic signed [31:0] pid_q;
    logic [4:0]         shift_q;
    logic [CNT_W-1:0]   per_q;

    // stage 1: shift and magnitude
    logic signed [31:0] s_shift;
    logic [31:0]        s1_mag;
    logic               s1_dir;

    // stage 2: clamp to period
    logic [CNT_W-1:0]   per_min;
    logic               sat_c;
    logic [CNT_W-1:0]   duty_c;
    logic [CNT_W-1:0]   s2_duty;
    logic [CNT_W-1:0]   s2_per;
    logic               s2_dir;
    logic               s2_sat;

    // output stage
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   per_sh;
    logic [CNT_W-1:0]   per_ld;
    logic               last;
    logic               active;
    logic               dt_block;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pid_q   <= '0;
            shift_q <= '0;
            per_q   <= '0;
        end else begin
            pid_q   <= PID_OUT_Set;
            shift_q <= OUT_SHIFT_Set;
            per_q   <= PERIOD_Set;
        end
    end

    assign s_shift = pid_q >>> shift_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_mag <= '0;
            s1_dir <= DIR_FWD;
        end else begin
            s1_mag <= sat_abs(s_shift);
            s1_dir <= s_shift[31];
        end
    end

    assign per_min = (per_q < MIN_P) ? MIN_P : per_q;
    assign sat_c   = (s1_mag > 32'(per_min));
    assign duty_c  = sat_c ? per_min : s1_mag[CNT_W-1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_duty <= '0;
            s2_per  <= '0;
            s2_dir  <= DIR_FWD;
            s2_sat  <= 1'b0;
        end else begin
            s2_duty <= duty_c;
            s2_per  <= per_min;
            s2_dir  <= s1_dir;
            s2_sat  <= sat_c;
        end
    end

    // s2_per is zero straight out of reset; never let that reach the shadow.
    assign per_ld = (s2_per < MIN_P) ? MIN_P : s2_per;
    assign last   = (cnt >= per_sh - CNT_W'(1));
    assign active = (cnt < DUTY_REG);

`ifdef PWM_DEADTIME_EN
    logic dir_chg;

    assign dir_chg = EN & last & (s2_dir != DIR);

    pwm_deadtime #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_deadtime (
        .clk  (CLK),
        .rst  (RST),
        .en   (EN),
        .start(dir_chg),
        .block(dt_block)
    );
`else
    // No gate in this build; DEAD_CYCLES only keeps its name referenced.
    assign dt_block = (DEAD_CYCLES < 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            per_sh      <= CNT_W'(DEFAULT_PERIOD);
            DUTY_REG    <= '0;
            DIR         <= DIR_FWD;
            SAT         <= 1'b0;
            PWM_A       <= 1'b0;
            PWM_B       <= 1'b0;
            PERIOD_TICK <= 1'b0;
        end else if (!EN) begin
            // idle: shadows track stage 2 so the first period is current
            cnt         <= '0;
            PWM_A       <= 1'b0;
            PWM_B       <= 1'b0;
            PERIOD_TICK <= 1'b0;
            per_sh      <= per_ld;
            DUTY_REG    <= s2_duty;
            DIR         <= s2_dir;
            SAT         <= s2_sat;
        end else begin
            PERIOD_TICK <= last;
            PWM_A       <= active & ~dt_block & (DIR == DIR_FWD);
            PWM_B       <= active & ~dt_block & (DIR == DIR_REV);
            if (last) begin
                cnt      <= '0;
                per_sh   <= per_ld;
                DUTY_REG <= s2_duty;
                DIR      <= s2_dir;
                SAT      <= s2_sat;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
